knn_result_reader: RTL and testbench

Host-side drain engine for the KNN accelerator's result port. After the host finishes streaming reference and query vectors through the write side, this block raises the accelerator's `done`, waits for the sorter to settle, pulses `rd_en` for exactly K cycles, and captures each `(name, value)` pair into a local buffer. It then replays the pairs nearest-first to the host over a valid/ready stream with a last marker. It sits between `knnTop_regwrap` and the AXI register/stream wrapper.

---
 rtl/knn_result_reader.sv | 163 ++++++++++++++++
 tb/tb_knn_result_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_result_reader.sv
`default_nettype none
// ============================================================================
// knn_result_reader
//   Drain engine for the KNN accelerator result port. Raises the accelerator
//   done, waits for the sorter to settle, reads K (name, value) pairs into a
//   local buffer and replays them nearest-first over a valid/ready stream.
//   Optional build macro: KNN_READER_SKIP_EMPTY_EN (drop empty sorter slots
//   whose name is 32'hFFFF_FFFF).
// Revision: 1.0  initial release
// ============================================================================
module knn_result_reader #(
  parameter int dataWidth    = 32,
  parameter int maxK         = 8,
  parameter int settleCycles = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 drain,
  input  logic [31:0]          k,
  output logic                 acc_done,
  output logic                 acc_rd_en,
  input  logic [31:0]          acc_name,
  input  logic [dataWidth-1:0] acc_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_name,
  output logic [dataWidth-1:0] out_value,
  output logic                 out_last,
  output logic                 busy,
  output logic                 k_err
);

  localparam int AW = $clog2(maxK);
  localparam int CW = AW + 1;
  localparam int SW = (settleCycles > 1) ? $clog2(settleCycles) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FINISH = 2'd1,
    READ   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         k_eff;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         count;
  logic [CW-1:0]         rd_ptr;
  logic [SW-1:0]         settle_cnt;
  logic [31:0]           name_mem  [maxK];
  logic [dataWidth-1:0]  value_mem [maxK];

  logic                  store;
  logic                  capture;
  logic [CW-1:0]         ptr_nxt;
  logic                  k_bad;

  // Decide whether the pair on the accelerator bus goes into the buffer
`ifdef KNN_READER_SKIP_EMPTY_EN
  assign store = (acc_name != 32'hFFFF_FFFF);
`else
  assign store = 1'b1;
`endif

  // Accelerator output is valid at every edge ending an rd_en cycle
  assign capture = (state == READ) && acc_rd_en;
  assign ptr_nxt = rd_ptr + 1'b1;
  assign k_bad   = (k == 32'd0) || (k > 32'(maxK));

  // Result buffer, written in capture order (nearest first)
  always_ff @(posedge clk) begin
    if (capture && store) begin
      name_mem[count[AW-1:0]]  <= acc_name;
      value_mem[count[AW-1:0]] <= acc_value;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k_eff      <= '0;
      rd_cnt     <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      settle_cnt <= '0;
      acc_done   <= 1'b0;
      acc_rd_en  <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_name   <= '0;
      out_value  <= '0;
      busy       <= 1'b0;
      k_err      <= 1'b0;
    end else begin
      k_err <= 1'b0;
      case (state)
        IDLE: begin
          if (drain) begin
            k_err <= k_bad;
            k_eff <= (k > 32'(maxK)) ? CW'(maxK) : k[CW-1:0];
            if (k != 32'd0) begin
              state      <= FINISH;
              settle_cnt <= '0;
              rd_cnt     <= '0;
              count      <= '0;
              acc_done   <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        FINISH: begin
          // acc_done has been high settleCycles cycles when rd_en rises
          if (settle_cnt == SW'(settleCycles - 1)) begin
            state     <= READ;
            acc_rd_en <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        READ: begin
          if (acc_rd_en) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == k_eff - 1'b1) acc_rd_en <= 1'b0;
            if (store) count <= count + 1'b1;
          end else begin
            // the cycle after the last capture: leave READ
            acc_done <= 1'b0;
            if (count == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= DRAIN;
              rd_ptr    <= '0;
              out_valid <= 1'b1;
              out_name  <= name_mem[0];
              out_value <= value_mem[0];
              out_last  <= (count == CW'(1));
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              rd_ptr    <= ptr_nxt;
              out_name  <= name_mem[ptr_nxt[AW-1:0]];
              out_value <= value_mem[ptr_nxt[AW-1:0]];
              out_last  <= (ptr_nxt == count - 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_knn_result_reader.sv
`default_nettype none
// ============================================================================
// tb_knn_result_reader
//   Directed stimulus against an accelerator model; expected stream entries
//   are queued when a drain is issued and popped by an output monitor.
// Revision: 1.0  initial release
// ============================================================================
module tb_knn_result_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drain = 1'b0;
  logic [31:0] k = '0;
  logic        acc_done, acc_rd_en;
  logic [31:0] acc_name;
  logic [31:0] acc_value;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_name;
  logic [31:0] out_value;
  logic        out_last;
  logic        busy, k_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] name;
    logic [31:0] value;
    logic        last;
  } exp_t;

  exp_t sb[$];
  bit   rq[$];

  // accelerator model: pair index advances at every edge with rd_en high
  logic [31:0] mname [16];
  logic [31:0] mvalue[16];
  int          idx = 0;
  int          base = 0;

  knn_result_reader dut (
    .clk       (clk),
    .reset     (reset),
    .drain     (drain),
    .k         (k),
    .acc_done  (acc_done),
    .acc_rd_en (acc_rd_en),
    .acc_name  (acc_name),
    .acc_value (acc_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_name  (out_name),
    .out_value (out_value),
    .out_last  (out_last),
    .busy      (busy),
    .k_err     (k_err)
  );

  always #5 clk = ~clk;

  assign acc_name  = mname[(idx - base) & 15];
  assign acc_value = mvalue[(idx - base) & 15];

  always @(posedge clk) if (acc_rd_en) idx <= idx + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // host ready: follows the queued pattern while a result is offered
  always @(posedge clk) begin
    #1;
    if (out_valid && rq.size() > 0) out_ready = rq.pop_front();
    else out_ready = 1'b1;
  end

  // output monitor
  bit          prev_stall = 0;
  bit          expect_idle = 0;
  logic [64:0] prev_out;
  exp_t        e;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall  = 0;
      expect_idle = 0;
    end else begin
      if (expect_idle) begin
        chk("busy_after_last", 64'(busy), 64'd0);
        expect_idle = 0;
      end
      if (prev_stall && out_valid)
        chk("stall_stable", 64'({out_name, out_value, out_last}), 64'(prev_out));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(out_name), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("out_name", 64'(out_name), 64'(e.name));
          chk("out_value", 64'(out_value), 64'(e.value));
          chk("out_last", 64'(out_last), 64'(e.last));
          if (out_last) expect_idle = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_name, out_value, out_last};
    end
  end

  task automatic set_pair(input int i, input logic [31:0] n, input logic [31:0] v);
    mname[i]  = n;
    mvalue[i] = v;
  endtask

  task automatic expect_pair(input logic [31:0] n, input logic [31:0] v, input logic l);
    exp_t x;
    x.name = n; x.value = v; x.last = l;
    sb.push_back(x);
  endtask

  task automatic run_drain(input logic [31:0] kval, input int exp_rd,
                           input bit exp_err, input bit inject);
    int done_cyc = 0;
    int rd_cyc = 0;
    bit rd_seen = 0;
    bit injected = 0;
    base = idx;
    @(negedge clk); drain = 1'b1; k = kval;
    @(negedge clk); drain = 1'b0;
    chk("k_err_pulse", 64'(k_err), 64'(exp_err));
    if (exp_rd == 0) begin
      chk("k0_busy", 64'(busy), 64'd0);
      chk("k0_done", 64'(acc_done), 64'd0);
      @(negedge clk);
      chk("k0_err_clear", 64'(k_err), 64'd0);
      chk("k0_done_later", 64'(acc_done | busy), 64'd0);
      return;
    end
    for (int c = 0; c < 400; c++) begin
      if (!busy) break;
      if (acc_rd_en) begin rd_cyc++; rd_seen = 1; end
      else if (acc_done && !rd_seen) done_cyc++;
      if (c == 1) chk("k_err_one_cycle", 64'(k_err), 64'd0);
      if (inject && out_valid && !injected) begin
        drain = 1'b1; k = 32'd5; injected = 1;
      end else begin
        drain = 1'b0;
      end
      @(negedge clk);
    end
    drain = 1'b0;
    chk("busy_timeout", 64'(busy), 64'd0);
    chk("done_before_rd", 64'(done_cyc), 64'd10);
    chk("rd_en_cycles", 64'(rd_cyc), 64'(exp_rd));
    chk("done_low_end", 64'(acc_done), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) set_pair(i, 32'h100 + i, 32'h10 + i);
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(acc_done), 64'd0);
    chk("rst_rd_en", 64'(acc_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({out_valid, out_last, k_err}), 64'd0);
    chk("rst_data", 64'({out_name, out_value}), 64'd0);
    reset = 1'b0;

    // basic k=3
    set_pair(0, 1, 2); set_pair(1, 2, 5); set_pair(2, 0, 9);
    expect_pair(1, 2, 0); expect_pair(2, 5, 0); expect_pair(0, 9, 1);
    run_drain(3, 3, 0, 0);

    // backpressure
    set_pair(0, 7, 11); set_pair(1, 8, 12); set_pair(2, 9, 13);
    expect_pair(7, 11, 0); expect_pair(8, 12, 0); expect_pair(9, 13, 1);
    rq.push_back(1); rq.push_back(0); rq.push_back(0); rq.push_back(1); rq.push_back(1);
    run_drain(3, 3, 0, 0);

    // k=0
    run_drain(0, 0, 1, 0);

    // k=20 clamps to 8
    for (int i = 0; i < 8; i++) begin
      set_pair(i, 32'h20 + i, 32'h300 + i);
      expect_pair(32'h20 + i, 32'h300 + i, i == 7);
    end
    run_drain(20, 8, 1, 0);

    // reset during READ
    begin
      int rdc = 0;
      base = idx;
      set_pair(0, 4, 4); set_pair(1, 5, 5); set_pair(2, 6, 6);
      @(negedge clk); drain = 1'b1; k = 32'd3;
      @(negedge clk); drain = 1'b0;
      for (int c = 0; c < 100 && rdc < 2; c++) begin
        if (acc_rd_en) rdc++;
        if (rdc < 2) @(negedge clk);
      end
      chk("pre_reset_rd", 64'(rdc), 64'd2);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("async_rd_en", 64'(acc_rd_en), 64'd0);
      chk("async_done", 64'(acc_done), 64'd0);
      chk("async_busy", 64'(busy), 64'd0);
      @(negedge clk);
      sb.delete();
      reset = 1'b0;
    end
    set_pair(0, 42, 77);
    expect_pair(42, 77, 1);
    run_drain(1, 1, 0, 0);

    // drain pulse while streaming is ignored
    set_pair(0, 3, 30); set_pair(1, 6, 60);
    expect_pair(3, 30, 0); expect_pair(6, 60, 1);
    rq.push_back(0); rq.push_back(0); rq.push_back(1); rq.push_back(1);
    run_drain(2, 2, 0, 1);
    @(negedge clk);
    chk("inject_idle", 64'({busy, acc_done}), 64'd0);

    // empty-slot handling
    set_pair(0, 1, 2); set_pair(1, 32'hFFFF_FFFF, 0);
    set_pair(2, 3, 4); set_pair(3, 32'hFFFF_FFFF, 0);
`ifdef KNN_READER_SKIP_EMPTY_EN
    expect_pair(1, 2, 0); expect_pair(3, 4, 1);
    run_drain(4, 4, 0, 0);
    for (int i = 0; i < 4; i++) set_pair(i, 32'hFFFF_FFFF, 0);
    run_drain(4, 4, 0, 0);
`else
    expect_pair(1, 2, 0); expect_pair(32'hFFFF_FFFF, 0, 0);
    expect_pair(3, 4, 0); expect_pair(32'hFFFF_FFFF, 0, 1);
    run_drain(4, 4, 0, 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
